// File: rtl/projectile_pkg.sv
// projectile_pkg: shared sprite/screen constants, slot record and tracker state type
package projectile_pkg;
    localparam int SPR_W    = 40;
    localparam int SPR_H    = 40;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
    } proj_slot_t;
    typedef enum logic [0:0] {IDLE = 1'b0, UPDATE = 1'b1} tracker_state_t;
endpackage

// File: rtl/projectile_180_tracker_if.sv
// projectile_180_tracker_if: spawn handshake, pixel bus and render outputs (active_count present with PROJ_TRACKER_STATS_EN)
interface projectile_180_tracker_if #(parameter int N_PROJ = 8);
    logic              frame_tick;
    logic              spawn_valid;
    logic [9:0]        spawn_x;
    logic [9:0]        spawn_y;
    logic              spawn_ready;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              sprite_on;
    logic [10:0]       rom_address;
    logic [N_PROJ-1:0] active_mask;
`ifdef PROJ_TRACKER_STATS_EN
    logic [4:0]        active_count;
    modport master (output frame_tick, spawn_valid, spawn_x, spawn_y, DrawX, DrawY, blank,
                    input spawn_ready, sprite_on, rom_address, active_mask, active_count);
    modport slave  (input frame_tick, spawn_valid, spawn_x, spawn_y, DrawX, DrawY, blank,
                    output spawn_ready, sprite_on, rom_address, active_mask, active_count);
`else
    modport master (output frame_tick, spawn_valid, spawn_x, spawn_y, DrawX, DrawY, blank,
                    input spawn_ready, sprite_on, rom_address, active_mask);
    modport slave  (input frame_tick, spawn_valid, spawn_x, spawn_y, DrawX, DrawY, blank,
                    output spawn_ready, sprite_on, rom_address, active_mask);
`endif
endinterface

// File: rtl/proj_hit_test.sv
// proj_hit_test: rectangle test of one slot against the current pixel plus sprite ROM offset
module proj_hit_test
    import projectile_pkg::*;
#(
    parameter int SPR_W = projectile_pkg::SPR_W,
    parameter int SPR_H = projectile_pkg::SPR_H
) (
    input  proj_slot_t  slot,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        hit,
    output logic [10:0] offset
);
    logic [10:0] px, py, sx, sy, dx, dy;
    assign px = {1'b0, draw_x};
    assign py = {1'b0, draw_y};
    assign sx = {1'b0, slot.x};
    assign sy = {1'b0, slot.y};
    assign dx = px - sx;
    assign dy = py - sy;
    assign hit = slot.active && px >= sx && px < sx + 11'(SPR_W) && py >= sy && py < sy + 11'(SPR_H);
    assign offset = dx + dy * 11'(SPR_W);
endmodule

// File: rtl/projectile_180_tracker.sv
// projectile_180_tracker: slot table, per-frame leftward move and pixel hit path (optional active_count via PROJ_TRACKER_STATS_EN)
module projectile_180_tracker
    import projectile_pkg::*;
#(
    parameter int N_PROJ = 8,
    parameter int SPR_W  = projectile_pkg::SPR_W,
    parameter int SPR_H  = projectile_pkg::SPR_H,
    parameter int SPEED  = 4
) (
    input logic                     vga_clk,
    input logic                     reset,
    projectile_180_tracker_if.slave bus
);
    localparam int IW = $clog2(N_PROJ);
    localparam logic [0:0] S_IDLE   = IDLE;
    localparam logic [0:0] S_UPDATE = UPDATE;

    proj_slot_t        slots [N_PROJ];
    logic [0:0]        state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     free_idx;
    logic [N_PROJ-1:0] act;
    logic [N_PROJ-1:0] hits;
    logic [10:0]       offs [N_PROJ];
    logic              sel_hit;
    logic [10:0]       sel_off;

    // active bits and lowest-index free slot for the spawn handshake
    always_comb begin
        free_idx = '0;
        for (int i = N_PROJ - 1; i >= 0; i--) begin
            act[i] = slots[i].active;
            if (!slots[i].active) free_idx = IW'(i);
        end
    end

    assign bus.spawn_ready = (state == S_IDLE) && !(&act);

    // spawn loading in IDLE, one slot moved/retired per cycle in UPDATE
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            for (int i = 0; i < N_PROJ; i++) slots[i] <= '0;
        end else if (state == S_IDLE) begin
            if (bus.spawn_valid && bus.spawn_ready)
                slots[free_idx] <= '{active: 1'b1, x: bus.spawn_x, y: bus.spawn_y};
            if (bus.frame_tick) begin
                state <= S_UPDATE;
                idx   <= '0;
            end
        end else begin
            if (slots[idx].active) begin
                if (slots[idx].x < 10'(SPEED)) slots[idx].active <= 1'b0;
                else slots[idx].x <= slots[idx].x - 10'(SPEED);
            end
            if (idx == IW'(N_PROJ - 1)) state <= S_IDLE;
            idx <= idx + 1'b1;
        end
    end

    for (genvar g = 0; g < N_PROJ; g++) begin : g_hit
        proj_hit_test #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
            .slot   (slots[g]),
            .draw_x (bus.DrawX),
            .draw_y (bus.DrawY),
            .hit    (hits[g]),
            .offset (offs[g])
        );
    end

    // priority pick: the lowest-index hitting slot supplies the ROM offset
    always_comb begin
        sel_hit = 1'b0;
        sel_off = '0;
        for (int i = N_PROJ - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel_hit = 1'b1;
                sel_off = offs[i];
            end
        end
    end

    // registered pixel outputs, forced to zero outside the visible region
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            bus.sprite_on   <= 1'b0;
            bus.rom_address <= '0;
            bus.active_mask <= '0;
        end else begin
            bus.sprite_on   <= sel_hit && bus.blank;
            bus.rom_address <= (sel_hit && bus.blank) ? sel_off : 11'd0;
            bus.active_mask <= act;
        end
    end

`ifdef PROJ_TRACKER_STATS_EN
    // live slot count, aligned with active_mask
    always_ff @(posedge vga_clk) begin
        if (reset) bus.active_count <= '0;
        else bus.active_count <= 5'($countones(act));
    end
`endif
endmodule

// File: tb/tb_projectile_180_tracker.sv
// tb_projectile_180_tracker: directed and random checks of the tracker against a frame-level slot model
module tb_projectile_180_tracker;
    import projectile_pkg::*;
    localparam int N = 8;
    localparam int SPD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    bit m_act [N];
    int m_x [N];
    int m_y [N];

    projectile_180_tracker_if #(.N_PROJ(N)) bus ();
    projectile_180_tracker #(.N_PROJ(N), .SPEED(SPD)) dut (.vga_clk(clk), .reset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_free();
        for (int i = 0; i < N; i++) if (!m_act[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = 0;
        for (int i = 0; i < N; i++) m[i] = m_act[i];
        return m;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0;
            m_x[i] = 0;
            m_y[i] = 0;
        end
    endtask

    task automatic m_spawn(input int x, input int y);
        for (int i = 0; i < N; i++) begin
            if (!m_act[i]) begin
                m_act[i] = 1;
                m_x[i] = x;
                m_y[i] = y;
                return;
            end
        end
    endtask

    task automatic m_frame();
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_x[i] < SPD) m_act[i] = 0;
                else m_x[i] -= SPD;
            end
        end
    endtask

    task automatic m_pixel(input int px, input int py, input bit b, output bit on, output int addr);
        bit found = 0;
        on = 0;
        addr = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && m_act[i] && px >= m_x[i] && px < m_x[i] + SPR_W && py >= m_y[i] && py < m_y[i] + SPR_H) begin
                found = 1;
                on = b;
                addr = b ? (px - m_x[i]) + (py - m_y[i]) * SPR_W : 0;
            end
        end
    endtask

    task automatic chk_mask(input string tag);
        chk({tag, ".active_mask"}, 32'(bus.active_mask), m_mask());
`ifdef PROJ_TRACKER_STATS_EN
        chk({tag, ".active_count"}, 32'(bus.active_count), 32'($countones(m_mask())));
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        bus.spawn_valid = 0;
        bus.frame_tick = 0;
        step();
        step();
        rst = 0;
        m_clear();
    endtask

    task automatic spawn(input int x, input int y);
        bus.spawn_valid = 1;
        bus.spawn_x = 10'(x);
        bus.spawn_y = 10'(y);
        #1;
        chk("spawn_ready_idle", 32'(bus.spawn_ready), 32'(m_free()));
        step();
        bus.spawn_valid = 0;
        m_spawn(x, y);
        step();
        chk_mask("spawn");
    endtask

    task automatic update_wait();
        for (int i = 0; i < N; i++) begin
            chk("spawn_ready_update", 32'(bus.spawn_ready), 0);
            step();
        end
        m_frame();
        step();
        chk("spawn_ready_after", 32'(bus.spawn_ready), 32'(m_free()));
        chk_mask("frame");
    endtask

    task automatic do_frame();
        bus.frame_tick = 1;
        step();
        bus.frame_tick = 0;
        update_wait();
    endtask

    task automatic pixel(input int px, input int py, input bit b);
        bit on;
        int addr;
        bus.DrawX = 10'(px);
        bus.DrawY = 10'(py);
        bus.blank = b;
        step();
        m_pixel(px, py, b, on, addr);
        chk("sprite_on", 32'(bus.sprite_on), 32'(on));
        chk("rom_address", 32'(bus.rom_address), 32'(addr));
    endtask

    initial begin
        bus.frame_tick = 0;
        bus.spawn_valid = 0;
        bus.spawn_x = 0;
        bus.spawn_y = 0;
        bus.DrawX = 0;
        bus.DrawY = 0;
        bus.blank = 0;
        m_clear();
        do_reset();
        chk("reset.sprite_on", 32'(bus.sprite_on), 0);
        chk("reset.rom_address", 32'(bus.rom_address), 0);
        chk("reset.active_mask", 32'(bus.active_mask), 0);
        chk("reset.spawn_ready", 32'(bus.spawn_ready), 1);

        spawn(100, 200);
        chk("first.mask", 32'(bus.active_mask), 32'h01);
        pixel(110, 205, 1);
        chk("first.addr210", 32'(bus.rom_address), 210);

        do_reset();
        spawn(6, 300);
        do_frame();
        pixel(2, 300, 1);
        chk("edge.addr0", 32'(bus.rom_address), 0);
        pixel(41, 339, 1);
        pixel(42, 300, 1);
        do_frame();
        chk("edge.retired", 32'(bus.active_mask), 0);
        pixel(2, 300, 1);

        do_reset();
        bus.spawn_valid = 1;
        for (int i = 0; i < N; i++) begin
            bus.spawn_x = 10'($urandom_range(0, SCREEN_W - 1));
            bus.spawn_y = 10'($urandom_range(0, SCREEN_H - 1));
            #1;
            chk("fill.ready", 32'(bus.spawn_ready), 1);
            m_spawn(int'(bus.spawn_x), int'(bus.spawn_y));
            step();
        end
        chk("full.ready", 32'(bus.spawn_ready), 0);
        for (int i = 0; i < 3; i++) begin
            bus.spawn_x = 10'($urandom_range(0, SCREEN_W - 1));
            step();
        end
        bus.spawn_valid = 0;
        step();
        chk("full.mask", 32'(bus.active_mask), 32'hFF);
        chk_mask("full");
        for (int i = 0; i < N; i++) pixel(m_x[i] + 39, m_y[i] + 39, 1);

        do_reset();
        spawn(100, 100);
        spawn(120, 100);
        pixel(125, 110, 1);
        chk("overlap.addr425", 32'(bus.rom_address), 425);
        pixel(125, 110, 0);
        chk("overlap.blank_off", 32'(bus.sprite_on), 0);
        pixel(145, 110, 1);

        do_reset();
        bus.spawn_valid = 1;
        bus.frame_tick = 1;
        bus.spawn_x = 10'd50;
        bus.spawn_y = 10'd50;
        step();
        bus.spawn_valid = 0;
        bus.frame_tick = 0;
        m_spawn(50, 50);
        update_wait();
        pixel(46, 50, 1);
        chk("combo.x46", 32'(bus.sprite_on), 1);
        pixel(85, 50, 1);
        pixel(86, 50, 1);

        do_reset();
        spawn(300, 100);
        spawn(200, 200);
        bus.DrawX = 10'd310;
        bus.DrawY = 10'd110;
        bus.blank = 1;
        bus.frame_tick = 1;
        step();
        bus.frame_tick = 0;
        step();
        step();
        rst = 1;
        step();
        chk("midrst.sprite_on", 32'(bus.sprite_on), 0);
        chk("midrst.rom_address", 32'(bus.rom_address), 0);
        chk("midrst.active_mask", 32'(bus.active_mask), 0);
        chk("midrst.ready", 32'(bus.spawn_ready), 1);
        rst = 0;
        m_clear();
        step();
        chk_mask("midrst");
        pixel(310, 110, 1);
        spawn(310, 120);
        pixel(315, 125, 1);

        do_reset();
        for (int it = 0; it < 80; it++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 4) begin
                spawn(int'($urandom_range(0, SCREEN_W - 1)), int'($urandom_range(0, SCREEN_H - 1)));
            end else if (r == 4) begin
                do_frame();
            end else begin
                int k = int'($urandom_range(0, N - 1));
                int px = int'($urandom_range(0, SCREEN_W - 1));
                int py = int'($urandom_range(0, SCREEN_H - 1));
                if (m_act[k]) begin
                    px = m_x[k] + int'($urandom_range(0, 49)) - 5;
                    py = m_y[k] + int'($urandom_range(0, 49)) - 5;
                    if (px < 0) px = 0;
                    if (py < 0) py = 0;
                end
                pixel(px, py, $urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/projectile_180_tracker.md
Name: projectile_180_tracker

Overview:
- Upstream stage of the leftward-travelling (180°) projectile sprite renderer.
- Owns up to N_PROJ live projectiles: accepts spawn requests, moves each active projectile left once per frame, and retires it at the left screen edge.
- Per pixel, decides whether (DrawX, DrawY) falls inside an active projectile. If so, emits the 40x40 sprite ROM address plus a registered hit flag, which the downstream ROM/palette stage consumes.

Parameters:
- N_PROJ, 8, number of projectile slots (2..16).
- SPR_W, 40, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- SPEED, 4, pixels moved left per frame_tick.

Ports:
- vga_clk  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- spawn_valid  in  1  spawn request.
- spawn_x  in  10  spawn left-edge x.
- spawn_y  in  10  spawn top-edge y.
- spawn_ready  out  1  spawn can be accepted this cycle.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- blank  in  1  1 = visible region.
- sprite_on  out  1  registered: pixel covered by an active projectile.
- rom_address  out  11  registered sprite ROM address.
- active_mask  out  N_PROJ  registered slot-active bits.

Behaviour:
- Reset (vga_clk edge with reset=1):
  - all slots inactive; x/y = 0.
  - FSM = IDLE; sprite_on = 0; rom_address = 0; active_mask = 0.
  - Reset mid-UPDATE aborts the update with no partial move retained.
- FSM IDLE:
  - spawn_ready = (IDLE && any slot inactive), combinational.
  - Spawn handshake: spawn_valid && spawn_ready at a clock edge loads the lowest-index inactive slot with spawn_x/spawn_y and sets it active.
  - frame_tick in IDLE moves the FSM to UPDATE with idx = 0.
  - Spawn and frame_tick in the same cycle: the spawn is accepted, and the new projectile is moved during that same UPDATE.
- FSM UPDATE: one slot per cycle, idx 0..N_PROJ-1.
  - Active slot with x < SPEED: cleared to inactive.
  - Other active slots: x <= x - SPEED.
  - Inactive slots: unchanged.
  - After idx = N_PROJ-1, return to IDLE. Update takes exactly N_PROJ cycles.
  - frame_tick during UPDATE is ignored.
  - spawn_ready = 0 throughout UPDATE.
- Pixel path, 1-cycle latency:
  - Hit test per slot uses 11-bit arithmetic to avoid overflow: active && DrawX >= x && DrawX < x+SPR_W && DrawY >= y && DrawY < y+SPR_H.
  - Lowest-index hit wins.
  - rom_address <= (DrawX - x) + (DrawY - y)*SPR_W, which is ≤ 1599.
  - sprite_on <= hit && blank.
  - No hit or blank=0: sprite_on <= 0 and rom_address <= 0.
- Partially off-screen sprites (y > 440 or x > 600): accepted; only the visible part is hit.
- Position updates take effect on the pixel path the cycle after they are written. UPDATE runs in vertical blanking, so no tearing occurs.

Optional Feature:
- Macro PROJ_TRACKER_STATS_EN.
- Defined: adds output active_count[4:0], registered popcount of active_mask, updated every cycle. Reset value 0.
- Undefined: port absent; no popcount logic.

Decomposition:
- Package projectile_pkg: SPR_W/SPR_H defaults, SCREEN_W = 640, SCREEN_H = 480, typedef proj_slot_t {active, x[9:0], y[9:0]}, enum tracker_state_t {IDLE, UPDATE}.
- One sub-module: proj_hit_test, combinational per-slot rectangle test and offset generation, instantiated N_PROJ times.

Test Plan:
- Reset, then spawn (100, 200) → slot 0 active, active_mask = 0x01. At DrawX = 110, DrawY = 205, blank = 1: one cycle later sprite_on = 1, rom_address = 210.
- Spawn at x = 6 with SPEED = 4. frame_tick → x = 2. Second frame_tick → slot retired, active_mask = 0.
- Fill all 8 slots → spawn_ready = 0. Further spawn_valid is ignored and active_mask stays 0xFF.
- Overlapping slots 0 (100, 100) and 1 (120, 100), pixel (125, 110) → rom_address = 425, slot 0 wins. Same pixel with blank = 0 → sprite_on = 0.
- spawn_valid together with frame_tick at (50, 50) → accepted, and x = 46 after the 8-cycle update. spawn_ready = 0 during those 8 cycles.
- Assert reset on the 3rd cycle of UPDATE → next cycle all outputs are 0 and the FSM is IDLE.
